// File: rtl/seq_detect_param.sv
// Parametrised serial pattern detector, advanced one symbol per rising edge of `next`.
// Reports the matched-prefix length, flags and counts matches, and can lock after N matches.
module seq_detect_param #(
    parameter int                 PAT_LEN      = 4,
    parameter logic [PAT_LEN-1:0] PATTERN      = 4'b0110,
    parameter int                 OVERLAP      = 1,
    parameter int                 LOCK_MATCHES = 0,
    parameter int                 CNT_W        = 8,
    localparam int                PW           = $clog2(PAT_LEN + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             next,
    input  logic             in,
    input  logic             clear,
    output logic [PW-1:0]    progress,
    output logic             out,
    output logic             match_pulse,
    output logic [CNT_W-1:0] match_count,
    output logic             locked
);

    if (PAT_LEN < 2 || PAT_LEN > 16) begin : g_bad_pat_len
        $error("seq_detect_param: PAT_LEN must be in 2..16");
    end
    if (LOCK_MATCHES < 0 || LOCK_MATCHES > (2 ** CNT_W) - 1) begin : g_bad_lock
        $error("seq_detect_param: LOCK_MATCHES must fit in the saturating counter");
    end

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [PW-1:0]    FULL    = PW'(PAT_LEN);

    logic               next_last_q;
    logic [PAT_LEN-1:0] hist_q, hist_d;
    logic [PW-1:0]      fill_q, fill_d;
    logic               restart_q, restart_d;
    logic [PW-1:0]      progress_q, progress_d;
    logic               out_q, out_d;
    logic               pulse_q, pulse_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               locked_q, locked_d;

    logic               step;
    logic [PAT_LEN-1:0] hist_shift;
    logic [PW-1:0]      fill_shift;
    logic [PW-1:0]      k_new;
    logic               is_match;
    logic [CNT_W-1:0]   count_inc;
    logic               lock_hit;

    // Longest k <= f whose newest k symbols equal the first k symbols of the pattern.
    function automatic logic [PW-1:0] prefix_len(input logic [PAT_LEN-1:0] h,
                                                 input logic [PW-1:0]      f);
        logic [PW-1:0]      best;
        logic [PAT_LEN-1:0] mask;
        best = '0;
        for (int k = 1; k <= PAT_LEN; k++) begin
            mask = {PAT_LEN{1'b1}} >> (PAT_LEN - k);
            if ((k <= int'(f)) && ((h & mask) == ((PATTERN >> (PAT_LEN - k)) & mask))) begin
                best = PW'(k);
            end
        end
        return best;
    endfunction

    assign step = next & ~next_last_q & ~locked_q & ~clear;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        hist_shift = restart_q ? {{(PAT_LEN-1){1'b0}}, in} : {hist_q[PAT_LEN-2:0], in};
        if (restart_q) begin
            fill_shift = PW'(1);
        end else if (fill_q == FULL) begin
            fill_shift = fill_q;
        end else begin
            fill_shift = fill_q + PW'(1);
        end
        k_new     = prefix_len(hist_shift, fill_shift);
        is_match  = (k_new == FULL);
        count_inc = (count_q == CNT_MAX) ? count_q : count_q + CNT_W'(1);
        lock_hit  = (LOCK_MATCHES != 0) && (count_inc == CNT_W'(LOCK_MATCHES));
    end

    always_comb begin
        hist_d     = hist_q;
        fill_d     = fill_q;
        restart_d  = restart_q;
        progress_d = progress_q;
        out_d      = out_q;
        pulse_d    = 1'b0;
        count_d    = count_q;
        locked_d   = locked_q;
        if (step) begin
            hist_d     = hist_shift;
            fill_d     = fill_shift;
            progress_d = k_new;
            out_d      = is_match;
            pulse_d    = is_match;
            restart_d  = is_match && (OVERLAP == 0);
            if (is_match) begin
                count_d  = count_inc;
                locked_d = lock_hit;
            end
        end
    end

    // The edge detector keeps tracking `next` through clear, so a held button
    // does not produce a fresh step when clear releases.
    always_ff @(posedge clk) begin
        if (reset) begin
            next_last_q <= 1'b0;
        end else begin
            next_last_q <= next;
        end
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            hist_q     <= '0;
            fill_q     <= '0;
            restart_q  <= 1'b0;
            progress_q <= '0;
            out_q      <= 1'b0;
            pulse_q    <= 1'b0;
            count_q    <= '0;
            locked_q   <= 1'b0;
        end else begin
            hist_q     <= hist_d;
            fill_q     <= fill_d;
            restart_q  <= restart_d;
            progress_q <= progress_d;
            out_q      <= out_d;
            pulse_q    <= pulse_d;
            count_q    <= count_d;
            locked_q   <= locked_d;
        end
    end

    assign progress    = progress_q;
    assign out         = out_q;
    assign match_pulse = pulse_q;
    assign match_count = count_q;
    assign locked      = locked_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param: four configurations share one stimulus stream
// (default, non-overlapping, lock-after-2, 2-bit counter) and are compared to hand-computed tables.
module tb_seq_detect_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, next, in, clear;

    logic [2:0] prog_def, prog_novl, prog_lock, prog_sat;
    logic       out_def, out_novl, out_lock, out_sat;
    logic       pls_def, pls_novl, pls_lock, pls_sat;
    logic [7:0] cnt_def, cnt_novl, cnt_lock;
    logic [1:0] cnt_sat;
    logic       lk_def, lk_novl, lk_lock, lk_sat;

    seq_detect_param u_def (
        .clk(clk), .reset(reset), .next(next), .in(in), .clear(clear),
        .progress(prog_def), .out(out_def), .match_pulse(pls_def),
        .match_count(cnt_def), .locked(lk_def)
    );
    seq_detect_param #(.OVERLAP(0)) u_novl (
        .clk(clk), .reset(reset), .next(next), .in(in), .clear(clear),
        .progress(prog_novl), .out(out_novl), .match_pulse(pls_novl),
        .match_count(cnt_novl), .locked(lk_novl)
    );
    seq_detect_param #(.LOCK_MATCHES(2)) u_lock (
        .clk(clk), .reset(reset), .next(next), .in(in), .clear(clear),
        .progress(prog_lock), .out(out_lock), .match_pulse(pls_lock),
        .match_count(cnt_lock), .locked(lk_lock)
    );
    seq_detect_param #(.CNT_W(2)) u_sat (
        .clk(clk), .reset(reset), .next(next), .in(in), .clear(clear),
        .progress(prog_sat), .out(out_sat), .match_pulse(pls_sat),
        .match_count(cnt_sat), .locked(lk_sat)
    );

    // One record per step; 4-bit fields are ordered {def, novl, lock, sat}.
    typedef struct {
        logic        sym;
        logic [15:0] prog;
        logic [3:0]  outv;
        logic [3:0]  pulse;
        logic [15:0] cnt;
        logic        lk;
    } vec_t;

    vec_t vecs [11];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [15:0] prog, input logic [3:0] outv,
                             input logic [3:0] pulse, input logic [15:0] cnt, input logic lk);
        check({tag, " prog def"},  32'(prog_def),  32'(prog[15:12]));
        check({tag, " prog novl"}, 32'(prog_novl), 32'(prog[11:8]));
        check({tag, " prog lock"}, 32'(prog_lock), 32'(prog[7:4]));
        check({tag, " prog sat"},  32'(prog_sat),  32'(prog[3:0]));
        check({tag, " out"},   32'({out_def, out_novl, out_lock, out_sat}), 32'(outv));
        check({tag, " pulse"}, 32'({pls_def, pls_novl, pls_lock, pls_sat}), 32'(pulse));
        check({tag, " cnt def"},  32'(cnt_def),  32'(cnt[15:12]));
        check({tag, " cnt novl"}, 32'(cnt_novl), 32'(cnt[11:8]));
        check({tag, " cnt lock"}, 32'(cnt_lock), 32'(cnt[7:4]));
        check({tag, " cnt sat"},  32'(cnt_sat),  32'(cnt[3:0]));
        check({tag, " locked lock"}, 32'(lk_lock), 32'(lk));
        check({tag, " locked others"}, 32'({lk_def, lk_novl, lk_sat}), 32'(0));
    endtask

    // Rising edge on next for one cycle; outputs are valid at the negedge on return.
    task automatic step(input logic sym);
        @(negedge clk);
        in   = sym;
        next = 1'b1;
        @(negedge clk);
        next = 1'b0;
    endtask

    initial begin
        //                sym   progress  out      pulse    count     locked
        vecs[0]  = '{1'b0, 16'h1111, 4'b0000, 4'b0000, 16'h0000, 1'b0};
        vecs[1]  = '{1'b1, 16'h2222, 4'b0000, 4'b0000, 16'h0000, 1'b0};
        vecs[2]  = '{1'b1, 16'h3333, 4'b0000, 4'b0000, 16'h0000, 1'b0};
        vecs[3]  = '{1'b0, 16'h4444, 4'b1111, 4'b1111, 16'h1111, 1'b0};
        vecs[4]  = '{1'b1, 16'h2022, 4'b0000, 4'b0000, 16'h1111, 1'b0};
        vecs[5]  = '{1'b1, 16'h3033, 4'b0000, 4'b0000, 16'h1111, 1'b0};
        vecs[6]  = '{1'b0, 16'h4144, 4'b1011, 4'b1011, 16'h2122, 1'b1};
        vecs[7]  = '{1'b0, 16'h1141, 4'b0010, 4'b0000, 16'h2122, 1'b1};
        vecs[8]  = '{1'b1, 16'h2242, 4'b0010, 4'b0000, 16'h2122, 1'b1};
        vecs[9]  = '{1'b1, 16'h3343, 4'b0010, 4'b0000, 16'h2122, 1'b1};
        vecs[10] = '{1'b0, 16'h4444, 4'b1111, 4'b1101, 16'h3223, 1'b1};

        reset = 1'b1;
        next  = 1'b0;
        in    = 1'b0;
        clear = 1'b0;
        repeat (2) @(negedge clk);
        check_all("reset", 16'h0000, 4'b0000, 4'b0000, 16'h0000, 1'b0);
        reset = 1'b0;

        // Overlap vs restart, lock hold, and counting over 0110110 + 0110.
        for (int i = 0; i < 11; i++) begin
            step(vecs[i].sym);
            check_all($sformatf("step%0d", i + 1), vecs[i].prog, vecs[i].outv,
                      vecs[i].pulse, vecs[i].cnt, vecs[i].lk);
        end

        // Pulse lasts one cycle while out holds until the next step.
        @(negedge clk);
        check("pulse drop", 32'({pls_def, pls_novl, pls_lock, pls_sat}), 32'(0));
        check("out hold", 32'({out_def, out_novl, out_lock, out_sat}), 32'(4'b1111));

        // Soft clear releases the lock and zeroes every output.
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check_all("clear", 16'h0000, 4'b0000, 4'b0000, 16'h0000, 1'b0);

        step(1'b0); step(1'b1); step(1'b1); step(1'b0);
        check_all("fresh", 16'h4444, 4'b1111, 4'b1111, 16'h1111, 1'b0);

        // 110 four more times: the 2-bit counter saturates but pulses keep firing.
        for (int r = 0; r < 4; r++) begin
            step(1'b1); step(1'b1); step(1'b0);
            check($sformatf("sat pulse r%0d", r), 32'(pls_sat), 32'(1));
            check($sformatf("sat cnt r%0d", r), 32'(cnt_sat), (r == 0) ? 32'(2) : 32'(3));
            check($sformatf("def cnt r%0d", r), 32'(cnt_def), 32'(r + 2));
            check($sformatf("lock lk r%0d", r), 32'(lk_lock), 32'(1));
            check($sformatf("lock cnt r%0d", r), 32'(cnt_lock), 32'(2));
        end

        // A step coinciding with clear is discarded, and the held next gives no later step.
        @(negedge clk);
        in    = 1'b0;
        next  = 1'b1;
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check_all("clear+step", 16'h0000, 4'b0000, 4'b0000, 16'h0000, 1'b0);
        repeat (3) @(negedge clk);
        check("clear held next", 32'(prog_def), 32'(0));
        next = 1'b0;
        @(negedge clk);

        // Held next: exactly one step per rising edge (a second step with in=1 would give 2).
        in   = 1'b0;
        next = 1'b1;
        @(negedge clk);
        in = 1'b1;
        repeat (9) @(negedge clk);
        check("hold1 prog", 32'(prog_def), 32'(1));
        in   = 1'b0;
        next = 1'b0;
        @(negedge clk);
        next = 1'b1;
        @(negedge clk);
        check("hold2 prog", 32'(prog_def), 32'(1));
        check("hold2 out", 32'(out_def), 32'(0));
        next = 1'b0;

        // Reset with next held high: one step on the first post-reset cycle.
        step(1'b0); step(1'b1); step(1'b1);
        check("pre-reset prog", 32'(prog_def), 32'(3));
        @(negedge clk);
        in    = 1'b0;
        next  = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_all("reset held", 16'h0000, 4'b0000, 4'b0000, 16'h0000, 1'b0);
        @(negedge clk);
        check("post-reset step", 32'(prog_def), 32'(1));
        in = 1'b1;
        repeat (3) @(negedge clk);
        check("post-reset hold", 32'(prog_def), 32'(1));
        next = 1'b0;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_detect_param.md
Name: seq_detect_param

Overview:
Parametrised serial pattern detector. It advances one symbol per rising edge of a debounced `next` step input, sampling the 1-bit `in` on each step. It generalises the fixed-table sequence FSMs to any pattern up to 16 bits, with these additions:
- overlapping or non-overlapping match mode
- a saturating match counter
- an optional sticky lock after N matches
- a synchronous soft clear

It sits behind the board button/switch inputs and drives the LED and seven-segment state display.

Parameters:
- PAT_LEN, 4, pattern length in symbols, 2..16.
- PATTERN, 4'b0110, target pattern [PAT_LEN-1:0]; PATTERN[PAT_LEN-1] is the first symbol expected.
- OVERLAP, 1, 1 = history kept after a match (overlapping); 0 = history restarts after a match.
- LOCK_MATCHES, 0, match count at which the block locks; 0 = lock disabled; must be <= 2^CNT_W-1.
- CNT_W, 8, width of the match counter.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- next  in  1  step request; a step occurs on its 0->1 transition
- in  in  1  serial symbol, sampled in the step cycle
- clear  in  1  synchronous soft clear (same effect as reset except next_last)
- progress  out  PW  PW=$clog2(PAT_LEN+1); matched-prefix length 0..PAT_LEN
- out  out  1  high from a matching step until the next step
- match_pulse  out  1  one-cycle pulse registered from the matching step
- match_count  out  CNT_W  saturating number of matches
- locked  out  1  block locked, steps ignored

Behaviour:
- Reset (synchronous, active-high): progress=0, out=0, match_pulse=0, match_count=0, locked=0. Internal hist=0, fill=0, restart=0, next_last=0.
- Step detect: next_last <= next every cycle (including during clear). step = next & ~next_last & ~locked & ~clear.
- Consequence: if next is held high across reset release, exactly one step occurs on the first post-reset cycle. If next is held high for many cycles, exactly one step occurs.
- History on step:
  - hist <= {hist[PAT_LEN-2:0], in}, newest symbol at bit 0.
  - fill <= min(fill+1, PAT_LEN).
  - If restart=1, the shift treats hist and fill as empty, so fill becomes 1 and only the new symbol is kept; restart then clears.
- progress: the largest k <= fill such that hist[k-1:0] == PATTERN[PAT_LEN-1 -: k]; 0 if none.
  - Computed from the updated history and registered, so it is valid the cycle after the step.
- Match: a step whose updated history gives k == PAT_LEN. In the following cycle:
  - out=1 and match_pulse=1.
  - match_count increments, saturating at 2^CNT_W-1.
  - If OVERLAP=0, restart is set.
- Non-matching step: out <= 0. match_pulse is 0 in every cycle except the one after a matching step.
- No step: all state holds.
- Lock: if LOCK_MATCHES != 0 and the incremented count == LOCK_MATCHES, locked <= 1 in the same cycle as the count update.
  - While locked, steps are ignored; progress, out and match_count hold.
  - Only reset or clear releases the lock.
- clear: one cycle, same effect as reset on every output and on hist/fill/restart. A step in the same cycle is discarded.
- Saturation: lock compares against the saturated count, which is why LOCK_MATCHES must be <= 2^CNT_W-1.
- Latency: step edge on next to outputs is 1 cycle after the cycle in which the edge is seen.

Test Plan:
1. Defaults (0110, OVERLAP=1); step symbols 0,1,1,0,1,1,0 -> progress 1,2,3,4,2,3,4; match_pulse after steps 4 and 7; match_count=2; out high after step 4, low after 5, high after 7.
2. OVERLAP=0, same stimulus -> progress 1,2,3,4,0,0,1; a single match at step 4; match_count=1.
3. next held high 10 cycles with in=0, then low, then high -> exactly 2 steps; progress=1 after each (history 0, then 00).
4. LOCK_MATCHES=2, stimulus of test 1 plus 4 extra steps (0,1,1,0) -> locked=1 after step 7; match_count stays 2 and progress stays 4 through the extra steps. Then pulse clear -> all outputs 0, locked=0, and a fresh 0110 gives match_count=1.
5. After 3 steps (0,1,1, progress=3), assert reset one cycle with next held high -> all outputs 0; first post-reset cycle registers one step with in=0 -> progress=1.
6. CNT_W=2, OVERLAP=1; step 0,1,1,0 followed by 1,1,0 four times -> 5 matches, match_count saturates at 3, and match_pulse still fires on every match.
